speed_ramp_ctrl: RTL
====================

// Module: speed_ramp_ctrl
// PURPOSE
//  Upstream of the pattern generators: turns raw up/down push-buttons and a pause switch into the
//  3-bit fixed-point step_size (UQ1.2, 0..1.75 px-units/frame) that pattern generators add to their
//  frame offset on next_frame. Debounces, auto-repeats, saturates, and ramps the output one LSB per frame.
// PARAMETERS
//  DEBOUNCE_FRAMES  2   consecutive next_frame samples a button must read high before a press registers
//  REPEAT_DELAY     30  frames a button is held after the press before the first auto-repeat event
//  REPEAT_RATE      8   frames between subsequent auto-repeat events
//  DEFAULT_STEP     4   reset/recall target step (4 = 1.00 px/frame)
//  MIN_STEP         1   lowest target step (never 0; only pause gives 0)
//  MAX_STEP         7   highest target step
// PORTS
//  clk         in   1  system clock (pixel clock)
//  rst_n       in   1  asynchronous active-low reset
//  next_frame  in   1  one-cycle pulse at frame start, from the timing generator
//  btn_up      in   1  raw asynchronous button, active high
//  btn_down    in   1  raw asynchronous button, active high
//  pause       in   1  raw asynchronous level switch, high = freeze motion
//  step_size   out  3  registered step to pattern generators, UQ1.2
//  at_max      out  1  target == MAX_STEP
//  at_min      out  1  target == MIN_STEP
// BEHAVIOUR
//  Reset (async, rst_n=0): all sync flops 0, button FSMs IDLE, counters 0, target=DEFAULT_STEP,
//   step_size=0, at_max=0, at_min=0 (flags are decoded from target; at_max/at_min registered with target).
//  Inputs btn_up/btn_down/pause pass through 2-flop synchronisers; only synced values used.
//  Button FSM (per button), evaluated only in cycles with next_frame=1, except release:
//   IDLE:     synced=1 on next_frame -> cnt=1, DEBOUNCE.
//   DEBOUNCE: synced=0 (any cycle) -> IDLE, cnt=0. next_frame & cnt+1==DEBOUNCE_FRAMES -> emit event, HELD, cnt=0.
//   HELD:     synced=0 -> IDLE. next_frame: cnt++; cnt+1==REPEAT_DELAY -> event, REPEAT, cnt=0.
//   REPEAT:   synced=0 -> IDLE. next_frame: cnt++; cnt+1==REPEAT_RATE -> event, cnt=0.
//   Event = one-cycle pulse in the cycle of that next_frame; release never emits an event.
//  Target update (same edge as event): up only -> min(target+1,MAX_STEP); down only ->
//   max(target-1,MIN_STEP); up and down same cycle -> DEFAULT_STEP. Saturation is silent.
//  Output ramp, on each next_frame edge (uses target value before that edge's update):
//   pause_sync=1 -> step_size moves 1 toward 0; else step_size moves 1 toward target; equal -> hold.
//   Hence pause decelerates to 0 and resume accelerates, each at 1 LSB/frame; stored target kept.
//  Latency: step_size changes on the next_frame edge; consumers sampling on that same next_frame see
//   the previous value, so a press affects motion 1 frame after the event frame (+1 per ramp LSB).
//  Width rules: all step arithmetic 3-bit unsigned, compared before +/-1, never wraps. Counters
//   sized $clog2(max(REPEAT_DELAY,REPEAT_RATE,DEBOUNCE_FRAMES)+1), saturate, cleared on state change.
//  next_frame absent: nothing changes except immediate return to IDLE on release.
//  Reset mid-ramp or mid-hold: immediate return to reset values; button held through reset must
//   re-debounce from IDLE (no event from the first post-reset frame).
// STRUCTURE
//  Shared package (pattern_pkg): STEP_W=3, STEP_FRAC_BITS=2, DEFAULT_STEP/MIN/MAX constants,
//   button FSM state enum {IDLE,DEBOUNCE,HELD,REPEAT}; also imported by the pattern generators.
//  One sub-module: button_conditioner (2-flop sync + FSM + counter, outputs event pulse),
//   instantiated for btn_up and btn_down; pause uses a bare 2-flop synchroniser in the top.
// TESTING
//  1 Reset, no buttons, 10 frames -> step_size ramps 0,1,2,3,4 then holds 4; at_max=at_min=0.
//  2 btn_up held 2 frames then released -> one event, target 5, step_size 4->5 next frame; 1-frame
//    glitch (high <DEBOUNCE_FRAMES) -> no event.
//  3 btn_up held 60 frames -> events at frames 2, 32, 40, 48, 56; target saturates 7, at_max=1, no wrap.
//  4 target 6, up+down pressed same frame -> target 4; btn_down repeated to floor -> target 1, at_min=1.
//  5 step 4, pause=1 for 8 frames -> 3,2,1,0,0..; pause=0 -> 1,2,3,4; target unchanged throughout.
//  6 rst_n pulsed low mid-ramp with btn_up held -> outputs reset immediately; first event only after
//    DEBOUNCE_FRAMES post-reset frames.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared step-size definitions for the speed ramp controller and the pattern generators.
// Steps are UQ1.2 pixel units per frame, held in STEP_W bits.
package pattern_pkg;

    localparam int STEP_W         = 3;
    localparam int STEP_FRAC_BITS = 2;

    localparam logic [STEP_W-1:0] STEP_ZERO    = 3'd0;
    localparam logic [STEP_W-1:0] STEP_ONE     = 3'd1;
    localparam logic [STEP_W-1:0] STEP_DEFAULT = 3'd4;
    localparam logic [STEP_W-1:0] STEP_MIN     = 3'd1;
    localparam logic [STEP_W-1:0] STEP_MAX     = 3'd7;

    localparam int DEF_DEBOUNCE_FRAMES = 2;
    localparam int DEF_REPEAT_DELAY    = 30;
    localparam int DEF_REPEAT_RATE     = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        REPEAT   = 2'd3
    } btn_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Bounds are checked before the +/-1 so the 3-bit value never wraps.
    function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v,
                                                  input logic [STEP_W-1:0] hi);
        return (v >= hi) ? hi : v + STEP_ONE;
    endfunction

    function automatic logic [STEP_W-1:0] sat_dec(input logic [STEP_W-1:0] v,
                                                  input logic [STEP_W-1:0] lo);
        return (v <= lo) ? lo : v - STEP_ONE;
    endfunction

    function automatic logic [STEP_W-1:0] step_toward(input logic [STEP_W-1:0] cur,
                                                      input logic [STEP_W-1:0] goal);
        if (cur < goal) return cur + STEP_ONE;
        if (cur > goal) return cur - STEP_ONE;
        return cur;
    endfunction

endpackage

// File: rtl/speed_ramp_ctrl_button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, frame-rate debounce and auto-repeat.
// event_o pulses in the cycle of the next_frame that completes a debounce or repeat interval.
module button_conditioner
    import pattern_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    input  logic next_frame_i,
    output logic event_o
);

    localparam int CNT_MAX = max3(DEBOUNCE_FRAMES, REPEAT_DELAY, REPEAT_RATE);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);

    logic             sync1_q;
    logic             sync2_q;
    btn_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_tc;
    logic             dly_tc;
    logic             rate_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
    assign db_tc   = (int'(cnt_q) + 1) == DEBOUNCE_FRAMES;
    assign dly_tc  = (int'(cnt_q) + 1) == REPEAT_DELAY;
    assign rate_tc = (int'(cnt_q) + 1) == REPEAT_RATE;

    // Release drops back to IDLE in any cycle; everything else advances only on next_frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (next_frame_i && sync2_q) begin
                        state_q <= DEBOUNCE;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!sync2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (next_frame_i) begin
                        if (db_tc) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                HELD: begin
                    if (!sync2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (next_frame_i) begin
                        if (dly_tc) begin
                            state_q <= REPEAT;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                REPEAT: begin
                    if (!sync2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (next_frame_i) begin
                        cnt_q <= rate_tc ? '0 : cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign event_o = next_frame_i && sync2_q &&
                     (((state_q == DEBOUNCE) && db_tc) ||
                      ((state_q == HELD)     && dly_tc) ||
                      ((state_q == REPEAT)   && rate_tc));

endmodule

// File: rtl/speed_ramp_ctrl.sv
// Speed ramp controller: turns up/down buttons and a pause switch into a step size that
// slews one LSB per frame toward the stored target (or toward zero while paused).
module speed_ramp_ctrl
    import pattern_pkg::*;
#(
    parameter int                DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int                REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int                REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter logic [STEP_W-1:0] DEFAULT_STEP    = STEP_DEFAULT,
    parameter logic [STEP_W-1:0] MIN_STEP        = STEP_MIN,
    parameter logic [STEP_W-1:0] MAX_STEP        = STEP_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              next_frame,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              pause,
    output logic [STEP_W-1:0] step_size,
    output logic              at_max,
    output logic              at_min
);

    logic              ev_up;
    logic              ev_dn;
    logic              pause_s1_q;
    logic              pause_s2_q;
    logic [STEP_W-1:0] target_q;
    logic [STEP_W-1:0] target_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic [STEP_W-1:0] goal;
    logic              at_max_q;
    logic              at_min_q;

    button_conditioner #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) u_btn_up (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw_i    (btn_up),
        .next_frame_i (next_frame),
        .event_o      (ev_up)
    );

    button_conditioner #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) u_btn_down (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw_i    (btn_down),
        .next_frame_i (next_frame),
        .event_o      (ev_dn)
    );

    // Simultaneous up and down events recall the default step.
    always_comb begin
        target_d = target_q;
        if (ev_up && ev_dn) begin
            target_d = DEFAULT_STEP;
        end else if (ev_up) begin
            target_d = sat_inc(target_q, MAX_STEP);
        end else if (ev_dn) begin
            target_d = sat_dec(target_q, MIN_STEP);
        end
    end

    // The ramp reads the pre-update target, so a new target shows up one frame later.
    assign goal   = pause_s2_q ? STEP_ZERO : target_q;
    assign step_d = next_frame ? step_toward(step_q, goal) : step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_s1_q <= 1'b0;
            pause_s2_q <= 1'b0;
            target_q   <= DEFAULT_STEP;
            step_q     <= STEP_ZERO;
            at_max_q   <= 1'b0;
            at_min_q   <= 1'b0;
        end else begin
            pause_s1_q <= pause;
            pause_s2_q <= pause_s1_q;
            target_q   <= target_d;
            step_q     <= step_d;
            at_max_q   <= (target_d == MAX_STEP);
            at_min_q   <= (target_d == MIN_STEP);
        end
    end

    assign step_size = step_q;
    assign at_max    = at_max_q;
    assign at_min    = at_min_q;

endmodule
